// File: rtl/mem_io_bridge_pkg.sv
// Shared sizing constants for the mesh io bridge.
package mem_io_bridge_pkg;
    localparam int unsigned MIB_PORTS      = 4;
    localparam int unsigned MIB_DATA_WIDTH = 8;
    localparam int unsigned MIB_PORT_WIDTH = 2;
    localparam int unsigned MIB_FIFO_DEPTH = 4;
endpackage

// File: rtl/mem_io_bridge_fifo.sv
// Synchronous per-port FIFO; pointers carry one extra wrap bit to tell full from empty.
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the mesh io bus and a tagged valid/ready stream in both directions.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int unsigned PORTS      = MIB_PORTS,
    parameter int unsigned DATA_WIDTH = MIB_DATA_WIDTH,
    parameter int unsigned PORT_WIDTH = MIB_PORT_WIDTH,
    parameter int unsigned FIFO_DEPTH = MIB_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            io_active_out,
    input  logic [PORTS*DATA_WIDTH-1:0] io_data_out,
    output logic [PORTS-1:0]            io_active_in,
    output logic [PORTS*DATA_WIDTH-1:0] io_data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PORT_WIDTH-1:0]       out_port,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PORT_WIDTH-1:0]       in_port,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        ovf_clear,
    output logic [PORTS-1:0]            overflow
);
    logic [PORTS-1:0]            fifo_empty;
    logic [PORTS-1:0]            fifo_full;
    logic [PORTS-1:0]            pop;
    logic [DATA_WIDTH-1:0]       head [PORTS];
    logic [PORT_WIDTH-1:0]       rr;
    logic [PORT_WIDTH-1:0]       grant;
    logic [PORT_WIDTH-1:0]       cand;
    logic                        any_ready;
    logic                        load;
    logic [PORTS-1:0]            ovf_set;
    logic [PORTS-1:0]            in_hit;
    logic [PORTS*DATA_WIDTH-1:0] in_data_next;

    for (genvar p = 0; p < PORTS; p++) begin : g_fifo
        io_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (io_active_out[p]),
            .push_data (io_data_out[p*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop[p]),
            .head      (head[p]),
            .empty     (fifo_empty[p]),
            .full      (fifo_full[p])
        );
    end

    // Search starts just after the last grant, so the last winner has lowest priority.
    always_comb begin
        grant     = '0;
        cand      = '0;
        any_ready = 1'b0;
        for (int unsigned i = 1; i <= PORTS; i++) begin
            cand = PORT_WIDTH'((32'(rr) + i) % PORTS);
            if (!any_ready && !fifo_empty[cand]) begin
                grant     = cand;
                any_ready = 1'b1;
            end
        end
    end

    assign load = (!out_valid || out_ready) && any_ready;

    always_comb begin
        pop          = '0;
        ovf_set      = '0;
        in_hit       = '0;
        in_data_next = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            pop[p]     = load && (grant == p[PORT_WIDTH-1:0]);
            ovf_set[p] = io_active_out[p] && fifo_full[p] && !pop[p];
            in_hit[p]  = in_ready && in_valid && (in_port == p[PORT_WIDTH-1:0]);
            if (in_hit[p]) in_data_next[p*DATA_WIDTH +: DATA_WIDTH] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr           <= PORT_WIDTH'(PORTS-1);
            out_valid    <= 1'b0;
            out_port     <= '0;
            out_data     <= '0;
            io_active_in <= '0;
            io_data_in   <= '0;
            overflow     <= '0;
            in_ready     <= 1'b0;
        end else begin
            in_ready     <= 1'b1;
            io_active_in <= in_hit;
            io_data_in   <= in_data_next;
            overflow     <= (overflow & ~{PORTS{ovf_clear}}) | ovf_set;
            if (load) begin
                out_valid <= 1'b1;
                out_port  <= grant;
                out_data  <= head[grant];
                rr        <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
